uop_sequencer: RTL and testbench

//  Fetch/decode/issue engine for the ECDSA curve microcode ROMs (init, double, add, conversion).

---
 rtl/uop_sequencer_pkg.sv | 62 ++++++
 rtl/uop_sequencer.sv | 134 +++++++++++++
 tb/tb_uop_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uop_sequencer_pkg.sv
// rtl/uop_sequencer_pkg.sv - shared microword field layout, opcodes, operand selects and exec codes
package uop_sequencer_pkg;

    localparam int OPCODE_W = 6;
    localparam int OPER_W   = 4;
    localparam int EXEC_W   = 2;
    localparam int UOP_BITS = OPCODE_W + 3 * OPER_W + EXEC_W;

    // Bit offsets of each field inside the microword, MSB first.
    localparam int OPCODE_LSB = 14;
    localparam int SRC1_LSB   = 10;
    localparam int SRC2_LSB   = 6;
    localparam int DST_LSB    = 2;
    localparam int EXEC_LSB   = 0;

    localparam logic [OPCODE_W-1:0] OPCODE_NOP = 6'h00;
    localparam logic [OPCODE_W-1:0] OPCODE_MOV = 6'h01;
    localparam logic [OPCODE_W-1:0] OPCODE_ADD = 6'h02;
    localparam logic [OPCODE_W-1:0] OPCODE_SUB = 6'h03;
    localparam logic [OPCODE_W-1:0] OPCODE_MUL = 6'h04;
    localparam logic [OPCODE_W-1:0] OPCODE_INV = 6'h05;
    localparam logic [OPCODE_W-1:0] OPCODE_RDY = 6'h3F;

    localparam logic [OPER_W-1:0] UOP_SRC_ZERO = 4'h0;
    localparam logic [OPER_W-1:0] UOP_SRC_ONE  = 4'h1;
    localparam logic [OPER_W-1:0] UOP_SRC_GX   = 4'h2;
    localparam logic [OPER_W-1:0] UOP_SRC_GY   = 4'h3;
    localparam logic [OPER_W-1:0] UOP_SRC_RX   = 4'h4;
    localparam logic [OPER_W-1:0] UOP_SRC_RY   = 4'h5;
    localparam logic [OPER_W-1:0] UOP_SRC_RZ   = 4'h6;
    localparam logic [OPER_W-1:0] UOP_SRC_T0   = 4'h7;

    localparam logic [OPER_W-1:0] UOP_DST_RX = 4'h4;
    localparam logic [OPER_W-1:0] UOP_DST_RY = 4'h5;
    localparam logic [OPER_W-1:0] UOP_DST_RZ = 4'h6;
    localparam logic [OPER_W-1:0] UOP_DST_T0 = 4'h7;

    typedef enum logic [EXEC_W-1:0] {
        UOP_EXEC_ALWAYS = 2'b00,
        UOP_EXEC_IF_SET = 2'b01,
        UOP_EXEC_IF_CLR = 2'b10,
        UOP_EXEC_RSVD   = 2'b11
    } uop_exec_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [OPER_W-1:0]   src1;
        logic [OPER_W-1:0]   src2;
        logic [OPER_W-1:0]   dst;
        logic [EXEC_W-1:0]   exec;
    } uop_t;

    // Reserved code 11 deliberately behaves like ALWAYS.
    function automatic logic exec_pass(input logic [EXEC_W-1:0] exec, input logic flag);
        logic ok;
        ok = 1'b1;
        if (exec == UOP_EXEC_IF_SET) ok = flag;
        if (exec == UOP_EXEC_IF_CLR) ok = ~flag;
        return ok;
    endfunction

endpackage

// File: rtl/uop_sequencer.sv
// rtl/uop_sequencer.sv - microcode fetch/decode/issue engine for the ECDSA curve ROMs
module uop_sequencer
    import uop_sequencer_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int UOP_W  = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    output logic                rdy,
    input  logic                flag,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [UOP_W-1:0]    rom_data,
    output logic                uop_ena,
    output logic [OPCODE_W-1:0] uop_opcode,
    output logic [OPER_W-1:0]   uop_src1,
    output logic [OPER_W-1:0]   uop_src2,
    output logic [OPER_W-1:0]   uop_dst,
    input  logic                uop_rdy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_WAIT   = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] PC_LAST = '1;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic                rdy_q;
    logic                uop_ena_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic [OPER_W-1:0]   src1_q;
    logic [OPER_W-1:0]   src2_q;
    logic [OPER_W-1:0]   dst_q;

    logic [OPCODE_W-1:0] dec_opcode;
    logic [OPER_W-1:0]   dec_src1;
    logic [OPER_W-1:0]   dec_src2;
    logic [OPER_W-1:0]   dec_dst;
    logic [EXEC_W-1:0]   dec_exec;
    logic                dec_is_rdy;
    logic                exec_ok;
    logic                step;

    assign dec_opcode = rom_data[OPCODE_LSB +: OPCODE_W];
    assign dec_src1   = rom_data[SRC1_LSB +: OPER_W];
    assign dec_src2   = rom_data[SRC2_LSB +: OPER_W];
    assign dec_dst    = rom_data[DST_LSB +: OPER_W];
    assign dec_exec   = rom_data[EXEC_LSB +: EXEC_W];
    assign dec_is_rdy = (dec_opcode == OPCODE_RDY);
    assign exec_ok    = exec_pass(dec_exec, flag);

    // A step retires the current word: either a skipped uop or an acknowledged issue.
    // The acknowledge is ignored in the strobe cycle itself.
    always_comb begin
        step = 1'b0;
        pc_d = pc_q + 1'b1;
        if (state_q == S_DECODE && !dec_is_rdy && !exec_ok) step = 1'b1;
        if (state_q == S_WAIT && uop_rdy && !uop_ena_q) step = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            rdy_q     <= 1'b1;
            uop_ena_q <= 1'b0;
            opcode_q  <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            dst_q     <= '0;
        end else begin
            uop_ena_q <= 1'b0;
            if (step) begin
                // Running off the end of program space ends the program instead of wrapping.
                if (pc_q == PC_LAST) begin
                    rdy_q   <= 1'b1;
                    pc_q    <= '0;
                    state_q <= S_IDLE;
                end else begin
                    pc_q    <= pc_d;
                    state_q <= S_FETCH;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (ena) begin
                            pc_q    <= '0;
                            rdy_q   <= 1'b0;
                            state_q <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        state_q <= S_DECODE;
                    end
                    S_DECODE: begin
                        if (dec_is_rdy) begin
                            rdy_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            opcode_q  <= dec_opcode;
                            src1_q    <= dec_src1;
                            src2_q    <= dec_src2;
                            dst_q     <= dec_dst;
                            uop_ena_q <= 1'b1;
                            state_q   <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        state_q <= S_WAIT;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rdy        = rdy_q;
    assign rom_addr   = pc_q;
    assign uop_ena    = uop_ena_q;
    assign uop_opcode = opcode_q;
    assign uop_src1   = src1_q;
    assign uop_src2   = src2_q;
    assign uop_dst    = dst_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// tb/tb_uop_sequencer.sv - directed table-driven bench for uop_sequencer with ROM and executor models
module tb_uop_sequencer;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        rdy;
    logic        flag;
    logic [5:0]  rom_addr;
    logic [19:0] rom_data;
    logic        uop_ena;
    logic [5:0]  uop_opcode;
    logic [3:0]  uop_src1;
    logic [3:0]  uop_src2;
    logic [3:0]  uop_dst;
    logic        uop_rdy;

    logic        resp_rdy;
    logic        spur_rdy;
    int          resp_cnt;
    int          rdy_delay;
    int          ecnt;
    int          n_pass;
    int          n_total;

    localparam logic [19:0] W_RDY    = 20'hFC000;
    localparam logic [19:0] W_MOV_RX = 20'h04410;
    localparam logic [19:0] W_MOV_RY = 20'h04414;
    localparam logic [19:0] W_MOV_RZ = 20'h04018;
    localparam logic [19:0] W_RY_IFS = 20'h04415;

    logic [19:0] rom [64];

    typedef struct {
        int         ed;
        int         addr;
        logic [17:0] fields;
    } iss_t;
    iss_t iss[$];

    typedef struct {
        logic [19:0] word;
        logic        flg;
        int          exp_n;
        logic [17:0] exp_fields;
        int          exp_done;
    } vec_t;
    vec_t vt[7];

    uop_sequencer #(.ADDR_W(6), .UOP_W(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .rdy        (rdy),
        .flag       (flag),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .uop_ena    (uop_ena),
        .uop_opcode (uop_opcode),
        .uop_src1   (uop_src1),
        .uop_src2   (uop_src2),
        .uop_dst    (uop_dst),
        .uop_rdy    (uop_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) ecnt <= ecnt + 1;

    assign uop_rdy = resp_rdy | spur_rdy;

    // Executor model: acknowledge rdy_delay cycles after the strobe cycle.
    always @(negedge clk) begin
        if (rst) begin
            resp_cnt = 0;
            resp_rdy = 1'b0;
        end else begin
            resp_rdy = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) resp_rdy = 1'b1;
            end
            if (uop_ena) resp_cnt = rdy_delay;
        end
    end

    always @(negedge clk) begin
        if (!rst && uop_ena)
            iss.push_back('{ed: ecnt, addr: int'(rom_addr),
                            fields: {uop_opcode, uop_src1, uop_src2, uop_dst}});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Called at a negedge; edge t0 is the next posedge, on which ena is sampled.
    task automatic run_prog(input int spur_lo, input int spur_hi, input int ena2, input int limit,
                            output int t0, output int done, output bit low0);
        iss.delete();
        t0   = ecnt + 1;
        done = -1;
        low0 = 1'b0;
        for (int i = 0; i < limit; i++) begin
            ena      = (i == 0) || (i == ena2);
            spur_rdy = (i >= spur_lo) && (i <= spur_hi);
            @(negedge clk);
            if (i == 0) low0 = !rdy;
            if (i > 0 && rdy) begin
                done = t0 + i;
                break;
            end
        end
        ena      = 1'b0;
        spur_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_init(input logic [19:0] w1);
        for (int k = 0; k < 64; k++) rom[k] = W_RDY;
        rom[0] = W_MOV_RX;
        rom[1] = w1;
        rom[2] = W_MOV_RZ;
        rom[3] = W_RDY;
    endtask

    initial begin
        int  t0;
        int  done;
        bit  low0;
        int  bad;

        n_pass    = 0;
        n_total   = 0;
        ecnt      = 0;
        rst       = 1'b1;
        ena       = 1'b0;
        flag      = 1'b0;
        spur_rdy  = 1'b0;
        rdy_delay = 1;
        for (int k = 0; k < 64; k++) rom[k] = W_RDY;

        vt[0] = '{20'h0440C, 1'b0, 1, {6'h01, 4'h1, 4'h0, 4'h3}, 6};
        vt[1] = '{20'h088D1, 1'b1, 1, {6'h02, 4'h2, 4'h3, 4'h4}, 6};
        vt[2] = '{20'h088D1, 1'b0, 0, {6'h02, 4'h2, 4'h3, 4'h4}, 4};
        vt[3] = '{20'h1159E, 1'b0, 1, {6'h04, 4'h5, 4'h6, 4'h7}, 6};
        vt[4] = '{20'h1159E, 1'b1, 0, {6'h04, 4'h5, 4'h6, 4'h7}, 4};
        vt[5] = '{20'hFBFFF, 1'b0, 1, {6'h3E, 4'hF, 4'hF, 4'hF}, 6};
        vt[6] = '{20'h16973, 1'b1, 1, {6'h05, 4'hA, 4'h5, 4'hC}, 6};

        repeat (3) @(negedge clk);
        chk("reset_rdy", 32'(rdy), 32'd1);
        chk("reset_uop_ena", 32'(uop_ena), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_fields", 32'({uop_opcode, uop_src1, uop_src2, uop_dst}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-word decode and exec-condition table.
        for (int v = 0; v < 7; v++) begin
            rom[0] = vt[v].word;
            rom[1] = W_RDY;
            flag   = vt[v].flg;
            run_prog(-1, -1, -1, 50, t0, done, low0);
            chk($sformatf("vec%0d_issues", v), 32'(iss.size()), 32'(vt[v].exp_n));
            chk($sformatf("vec%0d_fields", v), 32'({uop_opcode, uop_src1, uop_src2, uop_dst}),
                32'(vt[v].exp_fields));
            chk($sformatf("vec%0d_done", v), 32'(done), 32'(t0 + vt[v].exp_done));
            chk($sformatf("vec%0d_addr", v), 32'(rom_addr), 32'd1);
        end

        // Init program; ena re-pulsed on the cycle of the rdy-setting DECODE.
        load_init(W_MOV_RY);
        flag = 1'b0;
        run_prog(-1, -1, 14, 100, t0, done, low0);
        chk("init_busy", 32'(low0), 32'd1);
        chk("init_issues", 32'(iss.size()), 32'd3);
        if (iss.size() == 3) begin
            chk("init_ed0", 32'(iss[0].ed), 32'(t0 + 2));
            chk("init_ed1", 32'(iss[1].ed), 32'(t0 + 6));
            chk("init_ed2", 32'(iss[2].ed), 32'(t0 + 10));
            chk("init_addr2", 32'(iss[2].addr), 32'd2);
            chk("init_f0", 32'(iss[0].fields), 32'({6'h01, 4'h1, 4'h0, 4'h4}));
            chk("init_f1", 32'(iss[1].fields), 32'({6'h01, 4'h1, 4'h0, 4'h5}));
            chk("init_f2", 32'(iss[2].fields), 32'({6'h01, 4'h0, 4'h0, 4'h6}));
        end
        chk("init_done", 32'(done), 32'(t0 + 14));
        repeat (4) @(negedge clk);
        chk("init_no_restart", 32'(rdy), 32'd1);
        chk("init_addr_stop", 32'(rom_addr), 32'd3);

        // Conditional word 1 skipped with flag=0, issued with flag=1.
        load_init(W_RY_IFS);
        flag = 1'b0;
        run_prog(-1, -1, -1, 100, t0, done, low0);
        chk("skip_issues", 32'(iss.size()), 32'd2);
        if (iss.size() == 2) begin
            chk("skip_addr1", 32'(iss[1].addr), 32'd2);
            chk("skip_ed1", 32'(iss[1].ed), 32'(t0 + 8));
            chk("skip_f1", 32'(iss[1].fields), 32'({6'h01, 4'h0, 4'h0, 4'h6}));
        end
        chk("skip_done", 32'(done), 32'(t0 + 12));
        flag = 1'b1;
        run_prog(-1, -1, -1, 100, t0, done, low0);
        chk("set_issues", 32'(iss.size()), 32'd3);
        chk("set_done", 32'(done), 32'(t0 + 14));

        // Slow executor, spurious acks in IDLE/FETCH/DECODE/strobe cycle, ena while running.
        load_init(W_MOV_RY);
        flag      = 1'b0;
        rdy_delay = 10;
        run_prog(0, 3, 20, 100, t0, done, low0);
        chk("slow_issues", 32'(iss.size()), 32'd3);
        if (iss.size() == 3) begin
            chk("slow_ed0", 32'(iss[0].ed), 32'(t0 + 2));
            chk("slow_ed1", 32'(iss[1].ed), 32'(t0 + 15));
            chk("slow_ed2", 32'(iss[2].ed), 32'(t0 + 28));
            chk("slow_addr1", 32'(iss[1].addr), 32'd1);
        end
        chk("slow_done", 32'(done), 32'(t0 + 41));
        spur_rdy = 1'b1;
        @(negedge clk);
        spur_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_spur_addr", 32'(rom_addr), 32'd3);
        chk("idle_spur_rdy", 32'(rdy), 32'd1);
        chk("idle_spur_issues", 32'(iss.size()), 32'd3);

        // Full 64-word program without RDY ends at the last word, pc back to 0.
        rdy_delay = 1;
        for (int k = 0; k < 64; k++) begin
            logic [5:0] kk;
            kk = k[5:0];
            rom[k] = {6'h01, 4'h1, 4'h0, kk[3:0], 2'b00};
        end
        run_prog(-1, -1, -1, 300, t0, done, low0);
        chk("full_issues", 32'(iss.size()), 32'd64);
        bad = 0;
        foreach (iss[k]) if (iss[k].addr != k || iss[k].ed != t0 + 2 + 4 * k) bad++;
        chk("full_seq", 32'(bad), 32'd0);
        chk("full_done", 32'(done), 32'(t0 + 256));
        chk("full_pc0", 32'(rom_addr), 32'd0);
        repeat (6) @(negedge clk);
        chk("full_no_65th", 32'(iss.size()), 32'd64);

        // Reset while waiting on uop 2, then a clean rerun.
        load_init(W_MOV_RY);
        rdy_delay = 10;
        iss.delete();
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 60 && iss.size() < 2; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("rst_mid_issues", 32'(iss.size()), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rdy", 32'(rdy), 32'd1);
        chk("rst_mid_uop_ena", 32'(uop_ena), 32'd0);
        chk("rst_mid_addr", 32'(rom_addr), 32'd0);
        chk("rst_mid_fields", 32'({uop_opcode, uop_src1, uop_src2, uop_dst}), 32'd0);
        rdy_delay = 1;
        run_prog(-1, -1, -1, 100, t0, done, low0);
        chk("rerun_issues", 32'(iss.size()), 32'd3);
        if (iss.size() == 3) chk("rerun_addr0", 32'(iss[0].addr), 32'd0);
        chk("rerun_done", 32'(done), 32'(t0 + 14));

        // Empty program: word 0 is RDY.
        rom[0] = W_RDY;
        run_prog(-1, -1, -1, 50, t0, done, low0);
        chk("empty_busy", 32'(low0), 32'd1);
        chk("empty_done", 32'(done), 32'(t0 + 2));
        chk("empty_issues", 32'(iss.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
